psum_acc: RTL
=============

Name: psum_acc

Overview:
- Partial-sum accumulation stage directly upstream of the ReLU stage in the RepVGG conv datapath.
- Accumulates the 7-lane x 32-bit partial-sum vectors produced by the PE array over all input-channel tiles of one output tile, and adds the per-output-channel bias once.
- Emits the saturated result with a one-cycle valid pulse; that pulse drives the ReLU stage's enable, and dout feeds its data input.

Parameters:
- LANES, 7, number of parallel output pixels per vector.
- W, 32, lane width in bits, two's-complement signed.
- DW, LANES*W, total vector width.
- CW, 8, width of the input-channel tile count.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous abort of the tile in progress.
- ci_tiles  in  CW  number of partial-sum beats per output tile; sampled on the first beat of a tile.
- bias  in  W  signed per-output-channel bias; sampled on the first beat of a tile.
- din_valid  in  1  din carries a valid partial-sum vector this cycle.
- din  in  DW  partial sums; lane i = din[i*W +: W].
- dout  out  DW  accumulated, biased, saturated result; holds until the next result.
- dout_valid  out  1  one-cycle pulse when dout is updated; connects to ReLU en.
- busy  out  1  high while a tile is partially accumulated.
- beat_cnt  out  CW  beats accepted so far in the current tile.

Behaviour:
- Reset (rst=1 at a clock edge): dout=0, dout_valid=0, busy=0, beat_cnt=0, accumulator=0, state=IDLE. Reset overrides every other input.
- States:
  - IDLE: no tile in progress.
  - ACC: tile in progress; beat_cnt>0, busy=1.
- Effective tile count: N = ci_tiles latched on the first beat; ci_tiles=0 is treated as N=1.
- First beat (IDLE & din_valid):
  - per lane, acc = sat(din_i + bias).
  - latch N; beat_cnt <= 1.
  - If N==1: dout <= acc value, dout_valid <= 1 next cycle, remain in IDLE with beat_cnt=0. Otherwise go to ACC.
- Later beat (ACC & din_valid):
  - per lane, acc = sat(acc_i + din_i); beat_cnt++.
  - When the incoming beat is beat N (beat_cnt==N-1 before the update): dout <= sat(acc_i + din_i), dout_valid=1 the next cycle, beat_cnt <= 0, go to IDLE.
- ci_tiles and bias changes during ACC are ignored.
- Cycles with din_valid=0 leave all state unchanged; dout_valid=0.
- Latency: dout/dout_valid update one cycle after the last beat is sampled. Back-to-back tiles are supported with no bubble: the first beat of the next tile may arrive in the cycle after the previous last beat.
- dout_valid is a single-cycle pulse; it is never high for two cycles unless two tiles complete on consecutive cycles (N=1 streaming).
- Saturation: each lane computes a W+1-bit signed sum. Results above 2^(W-1)-1 clamp to 0x7FFFFFFF; results below -2^(W-1) clamp to 0x80000000. Saturation applies on every accumulation step, not only at the end.
- clear=1: beat_cnt <= 0, accumulator <= 0, state <= IDLE, dout_valid <= 0. dout keeps its last value. din is ignored in that cycle. clear has lower priority than rst.
- Reset mid-tile: the partial tile is discarded and no dout_valid is produced for it.
- Lanes are fully independent; no cross-lane carry.

Test Plan:
- Reset: hold rst 2 cycles with din_valid=1 -> dout=0, dout_valid=0, busy=0, beat_cnt=0 throughout.
- Single-tile pass-through: ci_tiles=1, bias=5, din lanes 0..6 = 10,-20,0,1,-1,100,7 -> next cycle dout = 15,-15,5,6,4,105,12 with a one-cycle dout_valid pulse.
- Multi-beat accumulation: ci_tiles=3, bias=-2, three beats of all-lanes 4 with one idle cycle between beats -> dout lanes = 10, single dout_valid pulse one cycle after the third beat, busy high from after beat 1 until the result.
- Saturation: ci_tiles=2, bias=0, beats 0x7FFFFFF0 then 0x20 -> lane 0x7FFFFFFF; beats 0x80000010 then -0x20 -> lane 0x80000000.
- Abort and restart: ci_tiles=4, two beats, then clear=1 together with din_valid=1, then a fresh tile with ci_tiles=1, bias=0, din=3 -> no pulse for the aborted tile; dout=3 lanes; previous dout held until then.
- Back-to-back tiles with ci_tiles=0 (treated as 1), bias=1, din=0,1,2 on consecutive cycles -> dout_valid high 3 consecutive cycles with dout lanes = 1,2,3; ci_tiles changed mid-tile in an N=2 run is ignored.

Source files
------------

// File: rtl/psum_acc.sv
// -----------------------------------------------------------------------------
// psum_acc
//   Partial-sum accumulation stage feeding the ReLU stage. It sums the 7-lane
//   partial-sum vectors of all input-channel tiles of one output tile. The
//   per-output-channel bias is added on the first beat. Every step saturates
//   to the signed W-bit range. Each finished vector is published on dout
//   together with a one-cycle dout_valid pulse.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst         in   1   synchronous active-high reset (highest priority)
//   clear       in   1   synchronous abort of the tile in progress
//   ci_tiles    in   CW  beats per output tile (0 means 1), sampled on beat 1
//   bias        in   W   signed bias, sampled on beat 1
//   din_valid   in   1   din carries a partial-sum vector this cycle
//   din         in   DW  partial sums, lane i = din[i*W +: W]
//   dout        out  DW  accumulated, biased, saturated result (held)
//   dout_valid  out  1   one-cycle pulse when dout is updated
//   busy        out  1   tile partially accumulated (FSM is in ACC)
//   beat_cnt    out  CW  beats accepted so far in the current tile
//
// Handshake: din_valid is a valid-only qualifier with no ready. The block
// accepts a beat in every cycle where din_valid=1 and clear=0. dout_valid is
// a pulse with no back-pressure, and dout holds until the next pulse.
// -----------------------------------------------------------------------------
module psum_acc #(
    parameter int LANES = 7,
    parameter int W     = 32,
    parameter int DW    = LANES * W,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [CW-1:0] ci_tiles,
    input  logic [W-1:0]  bias,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          busy,
    output logic [CW-1:0] beat_cnt
);

    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] sum_vec;
    logic [CW-1:0] n_lat;
    logic [CW-1:0] eff_n;
    logic          first_beat;
    logic          last_beat;

    // Signed W-bit add that clamps instead of wrapping. The sign-extended
    // W+1-bit sum overflowed exactly when its top two bits disagree.
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1])
            sat_add = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            sat_add = s[W-1:0];
    endfunction

    // A tile count of zero is treated as a single-beat tile.
    assign eff_n      = (ci_tiles == '0) ? CW'(1) : ci_tiles;
    assign first_beat = (state == IDLE) && din_valid;
    // On the first beat, compare against the live count. On later beats,
    // compare against the latched count so that mid-tile changes are ignored.
    assign last_beat  = first_beat ? (eff_n == CW'(1))
                                   : (beat_cnt == (n_lat - CW'(1)));

    // The first beat adds the bias. Later beats add the running accumulator.
    always_comb begin
        sum_vec = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_vec[i*W +: W] = sat_add(first_beat ? bias : acc_q[i*W +: W],
                                        din[i*W +: W]);
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_nxt = state;
        if (clear)
            state_nxt = IDLE;
        else if (din_valid)
            state_nxt = last_beat ? IDLE : ACC;
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state == ACC);
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            n_lat      <= '0;
            beat_cnt   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (clear) begin
            // Drop the partial tile. dout keeps the last published result.
            acc_q      <= '0;
            beat_cnt   <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (din_valid) begin
                acc_q <= sum_vec;
                if (first_beat)
                    n_lat <= eff_n;
                if (last_beat) begin
                    dout       <= sum_vec;
                    dout_valid <= 1'b1;
                    beat_cnt   <= '0;
                end else begin
                    beat_cnt <= beat_cnt + CW'(1);
                end
            end
        end
    end

endmodule
